uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised, runtime-configurable UART receiver for the uart_16550 datapath: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits. Uses 16x oversampling with 3-sample majority vote. Reports parity, framing and break conditions per character, and buffers received characters with their status in an internal FIFO drained through a valid/ready interface. It sits between the pad-side serial input and the register/host interface.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz; the divisor table is computed from it at elaboration.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
- i_sys_clk  in  1  system clock; single clock domain.
- i_sys_rst_n  in  1  reset; synchronous, active-low.
- i_rx  in  1  asynchronous serial input; idle high.
- i_rx_uart_bps  in  3  baud select: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=9600.
- i_data_bits  in  2  character length: 0=5, 1=6, 2=7, 3=8 bits.
- i_parity_en  in  1  1 = a parity bit follows the data.
- i_parity_even  in  1  1 = even parity, 0 = odd parity.
- i_stop2  in  1  1 = two stop bits.
- o_data  out  8  head-of-FIFO character, LSB-first and right-justified; unused upper bits are 0.
- o_parity_err  out  1  parity error flag of the head entry.
- o_frame_err  out  1  framing error flag of the head entry.
- o_break  out  1  break flag of the head entry.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts the head entry.
- o_overrun  out  1  one-cycle pulse when a completed character is dropped because the FIFO is full.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Synchroniser.** i_rx passes through a 2-flop synchroniser. A third flop holds the previous synced value for edge detection. All flops reset to 1.
- **Tick generator.**
  - DIV = CLK_FREQ/(16*bps), truncated; one constant per bps code.
  - The tick counter counts 0..DIV-1 and emits a one-cycle tick at DIV-1.
  - The counter is held at 0 in IDLE and restarts at 0 on start detection.
- **Sample counter.** A 4-bit counter advances per tick, 0..15 per bit. Majority of the synced line at sample counts 7, 8 and 9 is the bit value, resolved on tick 9.
- **Configuration latch.** bps, data_bits, parity_en, parity_even and stop2 are latched on start detection. Changes mid-frame take effect on the next frame.
- **State machine.**
  - IDLE → START: on a synced falling edge (prev=1, cur=0).
  - START → IDLE: start-bit majority is 1 (false start; nothing is pushed).
  - START → DATA: start-bit majority is 0.
  - DATA → PARITY or STOP: after N bits, shifting LSB first. Goes to PARITY if parity_en, else STOP.
  - PARITY → STOP: after the parity bit is sampled.
  - STOP: samples stop bit 1. If stop2, samples stop bit 2 one bit-time later. Then goes to PUSH.
  - PUSH → IDLE: PUSH lasts one cycle. IDLE requires a fresh falling edge, so a line held low never retriggers.
- **Error flags.**
  - parity_err: XOR of the data bits and the parity bit ≠ (parity_even ? 0 : 1).
  - frame_err: any sampled stop bit is 0.
  - break: all data bits are 0, the parity bit (if enabled) is 0, and stop bit 1 is 0. frame_err is also set and data is 0x00.
- **FIFO.**
  - Entry width is 11 bits: {brk, ferr, perr, data[7:0]}. Show-ahead: outputs reflect the head entry whenever o_valid=1.
  - Pop when o_valid && i_ready.
  - Push in PUSH if not full, or if full with a simultaneous pop.
  - Otherwise the character is discarded and o_overrun pulses.
  - Pointers wrap modulo FIFO_DEPTH. Level = pushes − pops.
- **Reset.** A mid-frame reset returns the FSM to IDLE and empties the FIFO. The partial character is lost.

## Timing
- Reset values:
  - o_data=0, o_parity_err=0, o_frame_err=0, o_break=0.
  - o_valid=0, o_overrun=0, o_fifo_level=0.
  - FSM in IDLE; all counters 0.
- Start detect: the FSM leaves IDLE 3 cycles after the i_rx falling edge (2 sync cycles + 1 edge register).
- Bit sampling: bit k (start=0) is resolved at tick 16k+9 after start detection, ±1 cycle.
- Push: happens the cycle after the last stop-bit sample resolves. o_valid, o_data and flags update the following cycle.
- Pop: head advances the cycle after o_valid && i_ready. o_valid drops that cycle if the FIFO becomes empty.
- Throughput: one pop per cycle. Push and pop in the same cycle leave the level unchanged.
- o_overrun: a single-cycle pulse, registered, one cycle after the dropped PUSH.

## Test plan
- **8N1 at 115200, CLK_FREQ=50e6 (DIV=27, 432 cycles/bit).** Send 0x55 then 0xA3 with i_ready=1 → two entries: data=0x55 then 0xA3, all flags 0.
- **7E1.** Send 0x41 with a correct parity bit, then 0x41 with the parity bit inverted → first entry perr=0; second entry data=0x41, perr=1, ferr=0.
- **8N2 framing and break.**
  - Character 0x3C with the second stop bit forced 0 → ferr=1, brk=0.
  - Line held low for 12 bit-times → one entry: data=0x00, ferr=1, brk=1.
  - After the line is released, no further entry is pushed until a new falling edge.
- **Overrun, FIFO_DEPTH=4.** i_ready=0; send 5 characters → o_fifo_level=4, one o_overrun pulse, and the fifth character is dropped. Then assert i_ready → 4 pops in the original order, o_valid falls.
- **False start.** A 0-pulse on i_rx of 5 ticks' duration → no push, FSM back in IDLE. A following valid 0x96 is received correctly.
- **Reset mid-frame.** Assert i_sys_rst_n=0 for 1 cycle during data bit 4 → all outputs return to reset values and the FIFO is empty. A subsequent 0x0F (5N1, i_data_bits=0) → data=0x0F.

Source files
------------

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Runtime-configurable UART receiver. It accepts 5-8 data bits,
//            optional odd/even parity and 1 or 2 stop bits. The receiver uses
//            16x oversampling with a 3-sample majority vote. Each received
//            character is buffered with its parity/framing/break status in a
//            show-ahead FIFO, which is drained through a valid/ready
//            interface.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLK_FREQ    system clock frequency in Hz (sets the baud divisors)
//   FIFO_DEPTH  FIFO entries; power of two, minimum 2
// Ports
//   i_sys_clk      in   1   system clock
//   i_sys_rst_n    in   1   synchronous active-low reset
//   i_rx           in   1   asynchronous serial input, idle high
//   i_rx_uart_bps  in   3   baud select (2400..115200, 7 = 9600)
//   i_data_bits    in   2   character length 5..8 bits
//   i_parity_en    in   1   parity bit present
//   i_parity_even  in   1   1 = even parity, 0 = odd parity
//   i_stop2        in   1   two stop bits
//   o_data         out  8   head character, right-justified
//   o_parity_err   out  1   head parity error flag
//   o_frame_err    out  1   head framing error flag
//   o_break        out  1   head break flag
//   o_valid        out  1   FIFO not empty
//   i_ready        in   1   consumer takes the head entry
//   o_overrun      out  1   pulse: a completed character was dropped
//   o_fifo_level   out  AW+1  FIFO occupancy
// ============================================================================
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst_n,
  input  logic                          i_rx,
  input  logic [2:0]                    i_rx_uart_bps,
  input  logic [1:0]                    i_data_bits,
  input  logic                          i_parity_en,
  input  logic                          i_parity_even,
  input  logic                          i_stop2,
  output logic [7:0]                    o_data,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_break,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  // --------------------------------------------------------------------------
  // Elaboration-time constants
  // --------------------------------------------------------------------------
  localparam int DIV_2400   = CLK_FREQ / (16 * 2400);
  localparam int DIV_4800   = CLK_FREQ / (16 * 4800);
  localparam int DIV_9600   = CLK_FREQ / (16 * 9600);
  localparam int DIV_19200  = CLK_FREQ / (16 * 19200);
  localparam int DIV_38400  = CLK_FREQ / (16 * 38400);
  localparam int DIV_57600  = CLK_FREQ / (16 * 57600);
  localparam int DIV_115200 = CLK_FREQ / (16 * 115200);

  // The slowest rate has the largest divisor, so it sets the counter width.
  localparam int CW = $clog2(DIV_2400 + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_PUSH   = 3'd5
  } state_t;

  state_t state;
  state_t state_nx;

  // --------------------------------------------------------------------------
  // Input synchroniser and edge detector
  // --------------------------------------------------------------------------
  logic rx_s1;
  logic rx_s2;
  logic rx_prev;
  logic fall;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Only a genuine high-to-low transition starts a frame. A line that stays
  // low (for example after a break) cannot start another frame.
  assign fall = rx_prev & ~rx_s2;

  // --------------------------------------------------------------------------
  // Frame configuration, captured at start detection
  // --------------------------------------------------------------------------
  logic [2:0] bps_l;
  logic [1:0] nbits_l;
  logic       par_en_l;
  logic       par_even_l;
  logic       stop2_l;

  // --------------------------------------------------------------------------
  // Oversampling tick generator
  // --------------------------------------------------------------------------
  logic [CW-1:0] div_m1;
  logic [CW-1:0] tick_cnt;
  logic          tick;

  always_comb begin
    div_m1 = CW'(DIV_9600 - 1);
    case (bps_l)
      3'd0:    div_m1 = CW'(DIV_2400 - 1);
      3'd1:    div_m1 = CW'(DIV_4800 - 1);
      3'd2:    div_m1 = CW'(DIV_9600 - 1);
      3'd3:    div_m1 = CW'(DIV_19200 - 1);
      3'd4:    div_m1 = CW'(DIV_38400 - 1);
      3'd5:    div_m1 = CW'(DIV_57600 - 1);
      3'd6:    div_m1 = CW'(DIV_115200 - 1);
      default: div_m1 = CW'(DIV_9600 - 1);
    endcase
  end

  assign tick = (state != ST_IDLE) && (tick_cnt == div_m1);

  // The counter is held at 0 while idle. A frame therefore starts counting
  // from 0 on the cycle after the start edge is detected.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE || state == ST_PUSH || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sample counter and majority vote
  // --------------------------------------------------------------------------
  logic [3:0] samp_cnt;
  logic       s7;
  logic       s8;
  logic       bit_val;
  logic       resolve;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      samp_cnt <= 4'd0;
      s7       <= 1'b1;
      s8       <= 1'b1;
    end else if (state == ST_IDLE) begin
      samp_cnt <= 4'd0;
    end else if (tick) begin
      samp_cnt <= samp_cnt + 4'd1;
      if (samp_cnt == 4'd7) s7 <= rx_s2;
      if (samp_cnt == 4'd8) s8 <= rx_s2;
    end
  end

  // The third vote is the live synced line on the sample-9 tick.
  assign bit_val = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);
  assign resolve = tick && (samp_cnt == 4'd9);

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  logic [2:0] bit_idx;
  logic [2:0] last_idx;
  logic       stop_idx;
  logic       start_det;
  logic       push_req;

  assign last_idx = 3'd4 + {1'b0, nbits_l};

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    push_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          start_det = 1'b1;
          state_nx  = ST_START;
        end
      end
      ST_START: begin
        if (resolve) begin
          // A start bit that votes high was a glitch.
          state_nx = bit_val ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (resolve && (bit_idx == last_idx)) begin
          state_nx = par_en_l ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (resolve) begin
          state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (resolve && (!stop2_l || stop_idx)) begin
          state_nx = ST_PUSH;
        end
      end
      ST_PUSH: begin
        push_req = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Character assembly and status tracking
  // --------------------------------------------------------------------------
  logic [7:0] shift;
  logic       par_bit;
  logic       any_one;     // any data or parity bit sampled as 1
  logic       stop1_low;   // first stop bit sampled as 0
  logic       ferr;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      bps_l      <= 3'd0;
      nbits_l    <= 2'd0;
      par_en_l   <= 1'b0;
      par_even_l <= 1'b0;
      stop2_l    <= 1'b0;
      shift      <= 8'h00;
      bit_idx    <= 3'd0;
      stop_idx   <= 1'b0;
      par_bit    <= 1'b0;
      any_one    <= 1'b0;
      stop1_low  <= 1'b0;
      ferr       <= 1'b0;
    end else begin
      if (start_det) begin
        bps_l      <= i_rx_uart_bps;
        nbits_l    <= i_data_bits;
        par_en_l   <= i_parity_en;
        par_even_l <= i_parity_even;
        stop2_l    <= i_stop2;
        shift      <= 8'h00;
        bit_idx    <= 3'd0;
        stop_idx   <= 1'b0;
        par_bit    <= 1'b0;
        any_one    <= 1'b0;
        stop1_low  <= 1'b0;
        ferr       <= 1'b0;
      end
      if (resolve) begin
        case (state)
          ST_DATA: begin
            // Writing by index keeps the character right-justified and
            // leaves the unused upper bits at 0.
            shift[bit_idx] <= bit_val;
            any_one        <= any_one | bit_val;
            bit_idx        <= bit_idx + 3'd1;
          end
          ST_PARITY: begin
            par_bit <= bit_val;
            any_one <= any_one | bit_val;
          end
          ST_STOP: begin
            if (!bit_val) ferr <= 1'b1;
            if (!stop_idx) stop1_low <= ~bit_val;
            stop_idx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  logic perr_calc;
  logic brk_calc;

  // The unused high bits of shift are 0, so they do not affect the XOR.
  assign perr_calc = par_en_l && ((^shift ^ par_bit) != ~par_even_l);
  assign brk_calc  = ~any_one & stop1_low;

  // --------------------------------------------------------------------------
  // Show-ahead FIFO: {brk, ferr, perr, data[7:0]}
  // --------------------------------------------------------------------------
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          valid;
  logic          pop;
  logic          push;
  logic [10:0]   head;

  assign full  = (level == LEVEL_FULL);
  assign valid = (level != '0);
  assign pop   = valid && i_ready;
  // When the FIFO is full, a simultaneous pop frees a slot in the same cycle.
  assign push  = push_req && (!full || pop);

  always_ff @(posedge i_sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= {brk_calc, ferr, perr_calc, shift};
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      o_overrun <= push_req && !push;
    end
  end

  // The outputs are gated while the FIFO is empty. The storage is not reset,
  // so this keeps stale contents from appearing on the outputs.
  assign head         = mem[rd_ptr];
  assign o_valid      = valid;
  assign o_data       = valid ? head[7:0] : 8'h00;
  assign o_parity_err = valid & head[8];
  assign o_frame_err  = valid & head[9];
  assign o_break      = valid & head[10];
  assign o_fifo_level = level;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Directed self-checking bench for uart_rx_cfg at 115200 baud,
//            50 MHz (432 clocks per bit), with a 4-entry FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_cfg;

  localparam int BIT = 432;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [2:0] bps;
  logic [1:0] data_bits;
  logic       parity_en;
  logic       parity_even;
  logic       stop2;
  logic [7:0] data;
  logic       parity_err;
  logic       frame_err;
  logic       brk;
  logic       valid;
  logic       ready;
  logic       overrun;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic [10:0] got_q[$];

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ   (50_000_000),
    .FIFO_DEPTH (4)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst_n   (rst_n),
    .i_rx          (rx),
    .i_rx_uart_bps (bps),
    .i_data_bits   (data_bits),
    .i_parity_en   (parity_en),
    .i_parity_even (parity_even),
    .i_stop2       (stop2),
    .o_data        (data),
    .o_parity_err  (parity_err),
    .o_frame_err   (frame_err),
    .o_break       (brk),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_overrun     (overrun),
    .o_fifo_level  (fifo_level)
  );

  // Record every accepted entry and every overrun pulse. Inputs change just
  // after posedge, so sampling on negedge is race-free.
  always @(negedge clk) begin
    if (rst_n && valid && ready) got_q.push_back({brk, frame_err, parity_err, data});
    if (overrun) ovr_cnt++;
  end

  function automatic logic [10:0] entry_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 11'bx;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cyc(BIT);
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic pev, input logic s2);
    bps         = 3'd6;
    data_bits   = db;
    parity_en   = pe;
    parity_even = pev;
    stop2       = s2;
  endtask

  task automatic send_char(input logic [7:0] d, input int nb, input logic pe, input logic pb,
                           input logic s1, input logic two, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pe) drive_bit(pb);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rx = 1'b1;
    wait_cyc(16);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(2);
    @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++; if (brk !== 1'b0) begin errors++; $display("FAIL reset_brk: got %b want 0", brk); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_8n1;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    ready = 1'b1;
    got_q.delete();
    send_char(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_char(8'hA3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_cyc(10);
    @(negedge clk);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL 8n1_count: got %0d want 2", got_q.size()); end
    checks++; if (entry_at(0) !== 11'h055) begin errors++; $display("FAIL 8n1_first: got %h want 055", entry_at(0)); end
    checks++; if (entry_at(1) !== 11'h0A3) begin errors++; $display("FAIL 8n1_second: got %h want 0a3", entry_at(1)); end
  endtask

  task automatic test_7e1;
    // 0x41 (7 bits) has two ones, so the even parity bit is 0.
    set_cfg(2'd2, 1'b1, 1'b1, 1'b0);
    ready = 1'b1;
    got_q.delete();
    send_char(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    send_char(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_cyc(10);
    @(negedge clk);
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL 7e1_count: got %0d want 2", got_q.size()); end
    checks++; if (entry_at(0) !== 11'h041) begin errors++; $display("FAIL 7e1_good: got %h want 041", entry_at(0)); end
    checks++; if (entry_at(1) !== 11'h141) begin errors++; $display("FAIL 7e1_bad_parity: got %h want 141", entry_at(1)); end
  endtask

  task automatic test_8n2_frame_break;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b1);
    ready = 1'b1;
    got_q.delete();
    send_char(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_cyc(10);
    @(negedge clk);
    checks++; if (entry_at(0) !== 11'h23C) begin errors++; $display("FAIL 8n2_ferr: got %h want 23c", entry_at(0)); end
    got_q.delete();
    rx = 1'b0;
    wait_cyc(12 * BIT);
    rx = 1'b1;
    wait_cyc(3 * BIT);
    @(negedge clk);
    checks++; if (entry_at(0) !== 11'h600) begin errors++; $display("FAIL break_entry: got %h want 600", entry_at(0)); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL break_count: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_overrun;
    logic [7:0] chars [5];
    chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    ready = 1'b0;
    got_q.delete();
    ovr_cnt = 0;
    for (int i = 0; i < 5; i++) send_char(chars[i], 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovr_level_full: got %0d want 4", fifo_level); end
    checks++; if (ovr_cnt !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL ovr_head: got %h want 11", data); end
    @(posedge clk); #1;
    ready = 1'b1;
    wait_cyc(10);
    @(negedge clk);
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL ovr_pop_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (entry_at(i) !== {3'b000, chars[i]}) begin
        errors++; $display("FAIL ovr_order_%0d: got %h want %h", i, entry_at(i), {3'b000, chars[i]});
      end
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop: got %b want 0", valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovr_level_empty: got %0d want 0", fifo_level); end
  endtask

  task automatic test_false_start;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    ready = 1'b1;
    got_q.delete();
    rx = 1'b0;
    wait_cyc(5 * 27);
    rx = 1'b1;
    wait_cyc(2 * BIT);
    @(negedge clk);
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL false_start_push: got %0d want 0", got_q.size()); end
    @(posedge clk); #1;
    send_char(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_cyc(10);
    @(negedge clk);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL false_start_count: got %0d want 1", got_q.size()); end
    checks++; if (entry_at(0) !== 11'h096) begin errors++; $display("FAIL false_start_next: got %h want 096", entry_at(0)); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    d = 8'h77;
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    ready = 1'b0;
    send_char(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL mid_preload: got %0d want 1", fifo_level); end
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    wait_cyc(200);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", fifo_level); end
    checks++; if ({brk, frame_err, parity_err, data} !== 11'h000) begin
      errors++; $display("FAIL mid_outputs: got %h want 000", {brk, frame_err, parity_err, data});
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %b want 0", overrun); end
    @(posedge clk); #1;
    wait_cyc(2 * BIT);
    set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
    ready = 1'b1;
    got_q.delete();
    send_char(8'h0F, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_cyc(10);
    @(negedge clk);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL mid_after_count: got %0d want 1", got_q.size()); end
    checks++; if (entry_at(0) !== 11'h00F) begin errors++; $display("FAIL mid_after_data: got %h want 00f", entry_at(0)); end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_7e1;
    test_8n2_frame_break;
    test_overrun;
    test_false_start;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
